mem_ring_buffer: RTL and testbench

- Ring-buffer controller that turns a streaming word FIFO (push/pop with valid/ready) into single-word accesses on the shared word memory port (wr/rd enable, address, data, rd_ready, busy).
- Sits directly upstream of the memory and owns one address window [BASE_ADDR, BASE_ADDR+DEPTH-1].
- Used between the SPI/MIL receive paths and their transmit paths.
- Keeps one prefetched output word in a register so the pop side sees a zero-latency valid.

---
 rtl/mem_pkg.sv | 18 +
 rtl/ring_ptr.sv | 26 ++
 rtl/mem_ring_buffer.sv | 177 +++++++++++++++++
 tb/tb_mem_ring_buffer.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-path definitions: default word/address widths, their
// typedefs, and the ring-buffer controller state encoding.
package mem_pkg;

  localparam int unsigned MEM_DATAW = 16;
  localparam int unsigned MEM_ADDRW = 8;

  typedef logic [MEM_DATAW-1:0] data_t;
  typedef logic [MEM_ADDRW-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_WAIT = 2'd1,
    RD_WAIT = 2'd2,
    DRAIN   = 2'd3
  } rb_state_t;

endpackage

// File: rtl/ring_ptr.sv
// Ring index that counts 0..DEPTH-1 and wraps; clear has priority over inc.
module ring_ptr #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 64
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_reg;

  // Advance with wrap at DEPTH-1; reset and clear both return to slot 0.
  always_ff @(posedge clk) begin
    if (!nRst || clear) begin
      ptr_reg <= '0;
    end else if (inc) begin
      ptr_reg <= (ptr_reg == W'(DEPTH - 1)) ? '0 : ptr_reg + 1'b1;
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/mem_ring_buffer.sv
// Ring-buffer controller: maps a push/pop word stream onto single-word
// accesses of a shared memory window, keeping the head word prefetched
// in a register so the pop side sees valid without read latency.
module mem_ring_buffer
  import mem_pkg::*;
#(
  parameter int unsigned      DATAW      = MEM_DATAW,
  parameter int unsigned      ADDRW      = MEM_ADDRW,
  parameter logic [ADDRW-1:0] BASE_ADDR  = '0,
  parameter int unsigned      DEPTH      = 64,
  parameter int unsigned      RD_TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic [DATAW-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [DATAW-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
  output logic [ADDRW:0]   level,
  output logic             full,
  output logic             empty,
  output logic             rd_error,
  output logic             mem_wr_enable,
  output logic [ADDRW-1:0] mem_wr_addr,
  output logic [DATAW-1:0] mem_wr_data,
  output logic             mem_rd_enable,
  output logic [ADDRW-1:0] mem_rd_addr,
  input  logic [DATAW-1:0] mem_rd_data,
  input  logic             mem_rd_ready,
  input  logic             mem_busy
);

  localparam int unsigned TW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

  rb_state_t        state_reg;
  logic [ADDRW:0]   count_reg;
  logic             out_valid_reg;
  logic [DATAW-1:0] out_data_reg;
  logic             rd_error_reg;
  logic [TW-1:0]    timer_reg;
  logic             wr_en_reg;
  logic [ADDRW-1:0] wr_addr_reg;
  logic [DATAW-1:0] wr_data_reg;
  logic             rd_en_reg;
  logic [ADDRW-1:0] rd_addr_reg;

  logic [ADDRW-1:0] wptr;
  logic [ADDRW-1:0] rptr;
  logic             prefetch_pending;
  logic             push_fire;
  logic             rd_decide;
  logic             rd_capture;

  // The register slot is refilled before any new write is accepted, so a
  // waiting pop side is never starved by a busy push side.
  assign prefetch_pending = !out_valid_reg && (count_reg != '0);
  assign full             = (count_reg == (ADDRW+1)'(DEPTH));
  assign in_ready         = (state_reg == IDLE) && !mem_busy && !full && !flush && !prefetch_pending;
  assign push_fire        = in_valid && in_ready;
  assign rd_decide        = (state_reg == IDLE) && !mem_busy && !flush && prefetch_pending;
  assign rd_capture       = (state_reg == RD_WAIT) && mem_rd_ready && !flush;

  ring_ptr #(.W(ADDRW), .DEPTH(DEPTH)) u_wptr (
    .clk   (clk),
    .nRst  (nRst),
    .clear (flush),
    .inc   (push_fire),
    .ptr   (wptr)
  );

  ring_ptr #(.W(ADDRW), .DEPTH(DEPTH)) u_rptr (
    .clk   (clk),
    .nRst  (nRst),
    .clear (flush),
    .inc   (rd_capture),
    .ptr   (rptr)
  );

  // Words resident in memory: up on an accepted push, down when a read lands.
  always_ff @(posedge clk) begin
    if (!nRst || flush) begin
      count_reg <= '0;
    end else if (push_fire) begin
      count_reg <= count_reg + 1'b1;
    end else if (rd_capture) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  // Head-word register: loaded by a read response, emptied by pop or flush.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (rd_capture) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= mem_rd_data;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Access sequencer: issues one-cycle strobes and tracks their completion;
  // a flushed or timed-out access waits in DRAIN until memory goes idle.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      rd_error_reg <= 1'b0;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      rd_en_reg    <= 1'b0;
      rd_addr_reg  <= '0;
    end else begin
      wr_en_reg <= 1'b0;
      rd_en_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (rd_decide) begin
            rd_en_reg   <= 1'b1;
            rd_addr_reg <= BASE_ADDR + rptr;
            timer_reg   <= '0;
            state_reg   <= RD_WAIT;
          end else if (push_fire) begin
            wr_en_reg   <= 1'b1;
            wr_addr_reg <= BASE_ADDR + wptr;
            wr_data_reg <= in_data;
            state_reg   <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (flush) begin
            state_reg <= DRAIN;
          end else if (!wr_en_reg && !mem_busy) begin
            state_reg <= IDLE;
          end
        end
        RD_WAIT: begin
          if (flush) begin
            state_reg <= DRAIN;
          end else if (mem_rd_ready) begin
            state_reg <= IDLE;
          end else if (timer_reg == TW'(RD_TIMEOUT - 1)) begin
            rd_error_reg <= 1'b1;
            state_reg    <= DRAIN;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        DRAIN: begin
          if (!mem_busy) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign out_data      = out_data_reg;
  assign out_valid     = out_valid_reg;
  assign level         = count_reg + {{ADDRW{1'b0}}, out_valid_reg};
  assign empty         = (level == '0);
  assign rd_error      = rd_error_reg;
  assign mem_wr_enable = wr_en_reg;
  assign mem_wr_addr   = wr_addr_reg;
  assign mem_wr_data   = wr_data_reg;
  assign mem_rd_enable = rd_en_reg;
  assign mem_rd_addr   = rd_addr_reg;

endmodule

// File: tb/tb_mem_ring_buffer.sv
// Bench for mem_ring_buffer against a 3-cycle word memory that reports busy
// while an access is in flight; a queue scoreboard checks order and level.
module tb_mem_ring_buffer;
  import mem_pkg::*;

  localparam int unsigned DATAW = 16;
  localparam int unsigned ADDRW = 8;
  localparam logic [7:0]  BASE  = 8'h10;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned RDTO  = 8;

  logic             clk;
  logic             nRst;
  logic [DATAW-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [DATAW-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             flush;
  logic [ADDRW:0]   level;
  logic             full;
  logic             empty;
  logic             rd_error;
  logic             mem_wr_enable;
  logic [ADDRW-1:0] mem_wr_addr;
  logic [DATAW-1:0] mem_wr_data;
  logic             mem_rd_enable;
  logic [ADDRW-1:0] mem_rd_addr;
  logic [DATAW-1:0] mem_rd_data;
  logic             mem_rd_ready;
  logic             mem_busy;

  mem_ring_buffer #(
    .DATAW(DATAW), .ADDRW(ADDRW), .BASE_ADDR(BASE), .DEPTH(DEPTH), .RD_TIMEOUT(RDTO)
  ) dut (
    .clk(clk), .nRst(nRst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .level(level), .full(full), .empty(empty), .rd_error(rd_error),
    .mem_wr_enable(mem_wr_enable), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_enable(mem_rd_enable), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_rd_ready(mem_rd_ready), .mem_busy(mem_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- memory model ----------------
  logic [DATAW-1:0] mem_array [0:255];
  int               wcnt = 0;
  int               rcnt = 0;
  logic [DATAW-1:0] rdata_hold = '0;
  bit               hang = 1'b0;
  logic [7:0]       wr_addr_q[$];
  logic [7:0]       rd_addr_q[$];

  always @(posedge clk) begin
    if (mem_wr_enable) begin
      mem_array[mem_wr_addr] <= mem_wr_data;
      wcnt <= 3;
      wr_addr_q.push_back(mem_wr_addr);
    end else if (wcnt > 0) begin
      wcnt <= wcnt - 1;
    end
    if (mem_rd_enable) begin
      rd_addr_q.push_back(mem_rd_addr);
      if (!hang) begin
        rcnt       <= 3;
        rdata_hold <= mem_array[mem_rd_addr];
      end
    end else if (rcnt > 0) begin
      rcnt <= rcnt - 1;
    end
  end

  assign mem_busy     = (wcnt != 0) || (rcnt != 0);
  assign mem_rd_ready = (rcnt == 1);
  assign mem_rd_data  = mem_rd_ready ? rdata_hold : '0;

  // ---------------- checking helpers ----------------
  int          tests  = 0;
  int          fails  = 0;
  bit          push_seen, pop_seen;
  data_t       push_word, pop_word;
  data_t       sb[$];
  data_t       exp_word;
  int          base_idx;
  int          k;
  bit          ok;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    push_seen = in_valid && in_ready;
    push_word = in_data;
    pop_seen  = out_valid && out_ready;
    pop_word  = out_data;
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input data_t d);
    in_valid = 1'b1;
    in_data  = d;
    ok       = 1'b0;
    for (int n = 0; n < 80; n++) begin
      tick();
      if (push_seen) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    check("push_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_out_valid();
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("out_valid_arrives", 32'(ok), 32'd1);
  endtask

  task automatic pop_one(input data_t exp);
    wait_out_valid();
    check("pop_data", 32'(out_data), 32'(exp));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pop_taken", 32'(pop_seen), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"},  32'(out_data),  32'd0);
    check({tag, "_level"},     32'(level),     32'd0);
    check({tag, "_empty"},     32'(empty),     32'd1);
    check({tag, "_full"},      32'(full),      32'd0);
    check({tag, "_rd_error"},  32'(rd_error),  32'd0);
    check({tag, "_wr_en"},     32'(mem_wr_enable), 32'd0);
    check({tag, "_wr_addr"},   32'(mem_wr_addr),   32'd0);
    check({tag, "_wr_data"},   32'(mem_wr_data),   32'd0);
    check({tag, "_rd_en"},     32'(mem_rd_enable), 32'd0);
    check({tag, "_rd_addr"},   32'(mem_rd_addr),   32'd0);
  endtask

  task automatic do_reset();
    nRst = 1'b0;
    tick();
    tick();
    nRst = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef enum int {K_PUSH, K_POP, K_CHK} kind_t;
  typedef struct {
    kind_t      kind;
    logic [15:0] data;
    int         exp_level;
    bit         exp_full;
    bit         exp_empty;
  } vec_t;
  vec_t vecs [21];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nRst = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;

    // Three-word order test, then DEPTH+1 capacity test.
    vecs[0] = '{K_PUSH, 16'hA001, 1, 1'b0, 1'b0};
    vecs[1] = '{K_PUSH, 16'hA002, 2, 1'b0, 1'b0};
    vecs[2] = '{K_PUSH, 16'hA003, 3, 1'b0, 1'b0};
    vecs[3] = '{K_POP,  16'hA001, 2, 1'b0, 1'b0};
    vecs[4] = '{K_POP,  16'hA002, 1, 1'b0, 1'b0};
    vecs[5] = '{K_POP,  16'hA003, 0, 1'b0, 1'b0};
    vecs[6] = '{K_CHK,  16'h0000, 0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      vecs[7 + i]  = '{K_PUSH, 16'(16'hB001 + i), i + 1, 1'b0, 1'b0};
      vecs[14 + i] = '{K_POP,  16'(16'hB001 + i), 5 - i, 1'b0, 1'b0};
    end
    vecs[13] = '{K_CHK, 16'h0000, 6, 1'b1, 1'b0};
    vecs[20] = '{K_CHK, 16'h0000, 0, 1'b0, 1'b1};

    // Reset state.
    tick();
    tick();
    check_reset_state("reset");
    nRst = 1'b1;
    tick();

    for (int v = 0; v < 21; v++) begin
      case (vecs[v].kind)
        K_PUSH: begin
          push_one(vecs[v].data);
          check("vec_push_level", 32'(level), 32'(vecs[v].exp_level));
          $display("[TB] vec %0d push %h level=%0d", v, vecs[v].data, level);
        end
        K_POP: begin
          pop_one(vecs[v].data);
          check("vec_pop_level", 32'(level), 32'(vecs[v].exp_level));
          $display("[TB] vec %0d pop %h level=%0d", v, pop_word, level);
        end
        default: begin
          idle_cycles(12);
          check("vec_chk_level", 32'(level), 32'(vecs[v].exp_level));
          check("vec_chk_full",  32'(full),  32'(vecs[v].exp_full));
          check("vec_chk_empty", 32'(empty), 32'(vecs[v].exp_empty));
          check("vec_chk_in_ready", 32'(in_ready), 32'(!vecs[v].exp_full));
          $display("[TB] vec %0d check level=%0d full=%0d empty=%0d", v, level, full, empty);
        end
      endcase
    end

    // Wrap: 12 words in groups of three after a reset; addresses cycle the window.
    do_reset();
    base_idx = wr_addr_q.size();
    k = rd_addr_q.size();
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 3; j++) push_one(16'(16'hC100 + r * 3 + j));
      for (int j = 0; j < 3; j++) pop_one(16'(16'hC100 + r * 3 + j));
      $display("[TB] wrap round %0d done level=%0d", r, level);
    end
    check("wrap_wr_count", 32'(wr_addr_q.size() - base_idx), 32'd12);
    check("wrap_rd_count", 32'(rd_addr_q.size() - k), 32'd12);
    for (int i = 0; i < 12; i++) begin
      if (base_idx + i < wr_addr_q.size())
        check("wrap_wr_addr", 32'(wr_addr_q[base_idx + i]), 32'(BASE + 8'(i % DEPTH)));
      if (k + i < rd_addr_q.size())
        check("wrap_rd_addr", 32'(rd_addr_q[k + i]), 32'(BASE + 8'(i % DEPTH)));
    end

    // Flush during RD_WAIT: the late response must be dropped.
    push_one(16'hF001);
    push_one(16'hF002);
    idle_cycles(12);
    pop_one(16'hF001);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (mem_rd_enable) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("flush_rd_strobe_seen", 32'(ok), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle_cycles(10);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_level", 32'(level), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    push_one(16'hBEEF);
    pop_one(16'hBEEF);
    check("flush_wr_addr", 32'(wr_addr_q[$]), 32'(BASE));
    check("flush_rd_addr", 32'(rd_addr_q[$]), 32'(BASE));
    $display("[TB] flush sequence popped %h", pop_word);

    // Read timeout: memory swallows reads; error rises 8 cycles after strobe.
    hang = 1'b1;
    base_idx = rd_addr_q.size();
    push_one(16'hC001);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (mem_rd_enable) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("to_strobe_seen", 32'(ok), 32'd1);
    check("to_err_before", 32'(rd_error), 32'd0);
    check("to_rd_addr", 32'(mem_rd_addr), 32'(BASE + 8'd1));
    k = 0;
    while (!rd_error && k < 20) begin
      tick();
      k++;
    end
    check("to_err_latency", 32'(k), 32'(RDTO));
    idle_cycles(30);
    hang = 1'b0;
    pop_one(16'hC001);
    check("to_retried", 32'(rd_addr_q.size() - base_idx >= 2), 32'd1);
    for (int i = base_idx; i < rd_addr_q.size(); i++)
      check("to_retry_addr", 32'(rd_addr_q[i]), 32'(BASE + 8'd1));
    check("to_err_sticky", 32'(rd_error), 32'd1);
    $display("[TB] timeout sequence popped %h after %0d reads", pop_word, rd_addr_q.size() - base_idx);

    // Randomized traffic against the queue model.
    for (int c = 0; c < 500; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 9) < 3);
      tick();
      if (pop_seen) begin
        if (sb.size() == 0) begin
          check("rand_pop_on_empty", 32'd1, 32'(sb.size()));
        end else begin
          exp_word = sb.pop_front();
          check("rand_pop_data", 32'(pop_word), 32'(exp_word));
          $display("[TB] rand pop %h", pop_word);
        end
      end
      if (push_seen) sb.push_back(push_word);
      check("rand_level", 32'(level), 32'(sb.size()));
      check("rand_empty", 32'(empty), 32'(sb.size() == 0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 300 && sb.size() != 0; c++) begin
      tick();
      if (pop_seen) begin
        exp_word = sb.pop_front();
        check("drain_pop_data", 32'(pop_word), 32'(exp_word));
        $display("[TB] drain pop %h", pop_word);
      end
    end
    out_ready = 1'b0;
    check("drain_model_empty", 32'(sb.size()), 32'd0);
    tick();
    check("drain_level", 32'(level), 32'd0);

    // Reset while a write is in flight.
    push_one(16'hE001);
    idle_cycles(12);
    push_one(16'hE002);
    check("rst_mid_wr_strobe", 32'(mem_wr_enable), 32'd1);
    nRst = 1'b0;
    tick();
    check_reset_state("rst_mid_wr");
    nRst = 1'b1;
    push_one(16'hD00D);
    pop_one(16'hD00D);
    check("rst_next_wr_addr", 32'(wr_addr_q[$]), 32'(BASE));
    check("rst_next_rd_addr", 32'(rd_addr_q[$]), 32'(BASE));
    $display("[TB] reset sequence popped %h", pop_word);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
